gpio_apb_irq: RTL and testbench

GPIO_APB_IRQ -- requirements
Module: gpio_apb_irq

---
 rtl/gpio_pkg.sv | 47 ++++
 rtl/gpio_sync_edge.sv | 64 ++++++
 rtl/gpio_apb_irq.sv | 150 +++++++++++++++
 tb/tb_gpio_apb_irq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register map, interrupt mode
// encodings and the decoded APB request payload.
package gpio_pkg;

   localparam int unsigned APB_AW = 32;
   localparam int unsigned APB_DW = 32;
   localparam int unsigned APB_SW = APB_DW / 8;
   localparam int unsigned OFF_W  = 8;

   localparam logic [OFF_W-1:0] OFF_GPO      = 8'h00;
   localparam logic [OFF_W-1:0] OFF_GPI      = 8'h04;
   localparam logic [OFF_W-1:0] OFF_GPO_SET  = 8'h08;
   localparam logic [OFF_W-1:0] OFF_GPD      = 8'h0C;
   localparam logic [OFF_W-1:0] OFF_GPO_CLR  = 8'h10;
   localparam logic [OFF_W-1:0] OFF_GPO_TGL  = 8'h14;
   localparam logic [OFF_W-1:0] OFF_IRQ_EN   = 8'h18;
   localparam logic [OFF_W-1:0] OFF_IRQ_TYPE = 8'h1C;
   localparam logic [OFF_W-1:0] OFF_IRQ_POL  = 8'h20;
   localparam logic [OFF_W-1:0] OFF_IRQ_BOTH = 8'h24;
   localparam logic [OFF_W-1:0] OFF_IRQ_STAT = 8'h28;
   localparam logic [OFF_W-1:0] OFF_IRQ_PEND = 8'h2C;

   localparam logic IRQ_TYPE_LEVEL = 1'b0;
   localparam logic IRQ_TYPE_EDGE  = 1'b1;
   localparam logic IRQ_POL_LOW    = 1'b0;
   localparam logic IRQ_POL_HIGH   = 1'b1;

   // One APB cycle after decode: write commit, read load and masked data.
   typedef struct packed {
      logic [OFF_W-1:0]  off;
      logic              wr;
      logic              rd;
      logic [APB_DW-1:0] wdata;
      logic [APB_DW-1:0] bmask;
   } apb_req_t;

   // Expand byte strobes into a per-bit write mask.
   function automatic logic [APB_DW-1:0] byte_mask(input logic [APB_SW-1:0] pstb);
      logic [APB_DW-1:0] m;
      m = '0;
      for (int k = 0; k < int'(APB_SW); k++) begin
         m[8*k +: 8] = {8{pstb[k]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bit input synchroniser plus edge/level event detection for the
// GPIO interrupt status register.
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int unsigned NUM_IO      = 20,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [NUM_IO-1:0] gpi_i,
   input  logic [NUM_IO-1:0] irq_type_i,
   input  logic [NUM_IO-1:0] irq_pol_i,
   input  logic [NUM_IO-1:0] irq_both_i,
   output logic [NUM_IO-1:0] sync_o,
   output logic [NUM_IO-1:0] event_c
);

   logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IO-1:0] dly_q;
   logic [NUM_IO-1:0] last_c;
   logic [NUM_IO-1:0] rise_c;
   logic [NUM_IO-1:0] fall_c;

   // Synchroniser chain and the one-cycle-delayed copy of its last stage.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= '0;
         end
         dly_q <= '0;
      end else begin
         sync_q[0] <= gpi_i;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         dly_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign last_c = sync_q[SYNC_STAGES-1];
   assign rise_c = last_c & ~dly_q;
   assign fall_c = ~last_c & dly_q;
   assign sync_o = last_c;

   // Event select: edge mode picks rise/fall/both, level mode matches polarity.
   always_comb begin
      event_c = '0;
      for (int i = 0; i < int'(NUM_IO); i++) begin
         if (irq_type_i[i] == IRQ_TYPE_EDGE) begin
            if (irq_both_i[i]) begin
               event_c[i] = rise_c[i] | fall_c[i];
            end else if (irq_pol_i[i] == IRQ_POL_HIGH) begin
               event_c[i] = rise_c[i];
            end else begin
               event_c[i] = fall_c[i];
            end
         end else begin
            event_c[i] = (last_c[i] == irq_pol_i[i]);
         end
      end
   end

endmodule

// File: rtl/gpio_apb_irq.sv
// APB-attached GPIO block with set/clear/toggle outputs, direction control
// and a per-bit edge/level interrupt controller.
module gpio_apb_irq
   import gpio_pkg::*;
#(
   parameter int unsigned NUM_IO      = 20,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [31:0]       apb_addr,
   input  logic              apb_sel,
   input  logic              apb_write,
   input  logic              apb_ena,
   input  logic [31:0]       apb_wdata,
   input  logic [3:0]        apb_pstb,
   output logic [31:0]       apb_rdata,
   output logic              apb_rready,
   input  logic [NUM_IO-1:0] gpi,
   output logic [NUM_IO-1:0] gpo,
   output logic [NUM_IO-1:0] gpd,
   output logic              gpio_intr
);

   apb_req_t          req;
   logic [NUM_IO-1:0] wmask;
   logic [NUM_IO-1:0] wbits;

   logic [NUM_IO-1:0] gpo_q,  gpo_d;
   logic [NUM_IO-1:0] gpd_q,  gpd_d;
   logic [NUM_IO-1:0] en_q,   en_d;
   logic [NUM_IO-1:0] type_q, type_d;
   logic [NUM_IO-1:0] pol_q,  pol_d;
   logic [NUM_IO-1:0] both_q, both_d;
   logic [NUM_IO-1:0] stat_q, stat_d;
   logic [NUM_IO-1:0] stat_clr;
   logic [31:0]       rdata_q, rdata_d;
   logic [NUM_IO-1:0] rd_val;
   logic              intr_q, intr_d;

   logic [NUM_IO-1:0] sync_val;
   logic [NUM_IO-1:0] event_c;
   logic              unused_ok;

   gpio_sync_edge #(
      .NUM_IO      (NUM_IO),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clock      (clock),
      .rst_n      (rst_n),
      .gpi_i      (gpi),
      .irq_type_i (type_q),
      .irq_pol_i  (pol_q),
      .irq_both_i (both_q),
      .sync_o     (sync_val),
      .event_c    (event_c)
   );

   // Decode the APB phase; strobes gate every write action bit-for-bit.
   always_comb begin
      req.off   = apb_addr[OFF_W-1:0];
      req.wr    = apb_sel & apb_write & apb_ena;
      req.rd    = apb_sel & ~apb_write;
      req.wdata = apb_wdata;
      req.bmask = byte_mask(apb_pstb);
   end

   assign wmask = NUM_IO'(req.bmask);
   assign wbits = NUM_IO'(req.wdata & req.bmask);

   // Register write decode; event set wins over a same-cycle W1C.
   always_comb begin
      gpo_d    = gpo_q;
      gpd_d    = gpd_q;
      en_d     = en_q;
      type_d   = type_q;
      pol_d    = pol_q;
      both_d   = both_q;
      stat_clr = '0;
      if (req.wr) begin
         case (req.off)
            OFF_GPO:      gpo_d  = (gpo_q  & ~wmask) | wbits;
            OFF_GPO_SET:  gpo_d  = gpo_q | wbits;
            OFF_GPO_CLR:  gpo_d  = gpo_q & ~wbits;
            OFF_GPO_TGL:  gpo_d  = gpo_q ^ wbits;
            OFF_GPD:      gpd_d  = (gpd_q  & ~wmask) | wbits;
            OFF_IRQ_EN:   en_d   = (en_q   & ~wmask) | wbits;
            OFF_IRQ_TYPE: type_d = (type_q & ~wmask) | wbits;
            OFF_IRQ_POL:  pol_d  = (pol_q  & ~wmask) | wbits;
            OFF_IRQ_BOTH: both_d = (both_q & ~wmask) | wbits;
            OFF_IRQ_STAT: stat_clr = wbits;
            default:      ;
         endcase
      end
      stat_d = (stat_q & ~stat_clr) | event_c;
      intr_d = |(stat_q & en_q);
   end

   // Read mux; action registers and unmapped offsets read as zero.
   always_comb begin
      rd_val = '0;
      case (req.off)
         OFF_GPO:      rd_val = gpo_q;
         OFF_GPI:      rd_val = sync_val;
         OFF_GPD:      rd_val = gpd_q;
         OFF_IRQ_EN:   rd_val = en_q;
         OFF_IRQ_TYPE: rd_val = type_q;
         OFF_IRQ_POL:  rd_val = pol_q;
         OFF_IRQ_BOTH: rd_val = both_q;
         OFF_IRQ_STAT: rd_val = stat_q;
         OFF_IRQ_PEND: rd_val = stat_q & en_q;
         default:      rd_val = '0;
      endcase
      rdata_d = req.rd ? 32'(rd_val) : rdata_q;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         gpo_q   <= '0;
         gpd_q   <= '0;
         en_q    <= '0;
         type_q  <= '0;
         pol_q   <= '0;
         both_q  <= '0;
         stat_q  <= '0;
         rdata_q <= '0;
         intr_q  <= 1'b0;
      end else begin
         gpo_q   <= gpo_d;
         gpd_q   <= gpd_d;
         en_q    <= en_d;
         type_q  <= type_d;
         pol_q   <= pol_d;
         both_q  <= both_d;
         stat_q  <= stat_d;
         rdata_q <= rdata_d;
         intr_q  <= intr_d;
      end
   end

   assign gpo        = gpo_q;
   assign gpd        = gpd_q;
   assign gpio_intr  = intr_q;
   assign apb_rdata  = rdata_q;
   assign apb_rready = 1'b1;

   // Upper address bits and data/strobe bits above NUM_IO are don't-care.
   assign unused_ok = ^{apb_addr[31:OFF_W], req.wdata, req.bmask};

endmodule

// File: tb/tb_gpio_apb_irq.sv
// Directed bench for gpio_apb_irq: register map, byte strobes, interrupt
// modes and asynchronous reset, checked against a read scoreboard.
module tb_gpio_apb_irq;
   import gpio_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] val;
      bit          on8;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [31:0] apb_addr;
   logic        apb_sel, apb_write, apb_ena;
   logic [31:0] apb_wdata;
   logic [3:0]  apb_pstb;
   logic [31:0] apb_rdata, apb_rdata8;
   logic        apb_rready, apb_rready8;
   logic [19:0] gpi, gpo, gpd;
   logic [7:0]  gpi8, gpo8, gpd8;
   logic        gpio_intr, gpio_intr8;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clock = ~clock;

   gpio_apb_irq #(.NUM_IO(20), .SYNC_STAGES(2)) u_dut (
      .clock(clock), .rst_n(rst_n),
      .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_write(apb_write), .apb_ena(apb_ena),
      .apb_wdata(apb_wdata), .apb_pstb(apb_pstb), .apb_rdata(apb_rdata), .apb_rready(apb_rready),
      .gpi(gpi), .gpo(gpo), .gpd(gpd), .gpio_intr(gpio_intr)
   );

   gpio_apb_irq #(.NUM_IO(8), .SYNC_STAGES(2)) u_dut8 (
      .clock(clock), .rst_n(rst_n),
      .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_write(apb_write), .apb_ena(apb_ena),
      .apb_wdata(apb_wdata), .apb_pstb(apb_pstb), .apb_rdata(apb_rdata8), .apb_rready(apb_rready8),
      .gpi(gpi8), .gpo(gpo8), .gpd(gpd8), .gpio_intr(gpio_intr8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; commit happens on the posedge with apb_ena high.
   task automatic apb_wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
      apb_addr  = {24'h0, off};
      apb_wdata = data;
      apb_pstb  = strb;
      apb_sel   = 1'b1;
      apb_write = 1'b1;
      apb_ena   = 1'b0;
      @(negedge clock);
      apb_ena = 1'b1;
      @(negedge clock);
      apb_sel   = 1'b0;
      apb_write = 1'b0;
      apb_ena   = 1'b0;
   endtask

   // Called at a negedge; read data is checked during the access phase.
   task automatic apb_rd(input logic [7:0] off, input logic [31:0] exp, input bit on8, input string tag);
      exp_t e;
      sb.push_back('{tag, exp, on8});
      apb_addr  = {24'h0, off};
      apb_sel   = 1'b1;
      apb_write = 1'b0;
      apb_ena   = 1'b0;
      @(negedge clock);
      apb_ena = 1'b1;
      e = sb.pop_front();
      chk(e.tag, e.on8 ? apb_rdata8 : apb_rdata, e.val);
      @(negedge clock);
      apb_sel = 1'b0;
      apb_ena = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      apb_addr = '0; apb_sel = 1'b0; apb_write = 1'b0; apb_ena = 1'b0;
      apb_wdata = '0; apb_pstb = '0;
      gpi = '0; gpi8 = '0;
      repeat (3) @(negedge clock);
      chk("rst_gpo_pin", 32'(gpo), 32'h0);
      chk("rst_gpd_pin", 32'(gpd), 32'h0);
      chk("rst_intr",    32'(gpio_intr), 32'h0);
      chk("rst_rdata",   apb_rdata, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      apb_rd(OFF_GPO, 32'h0, 1'b0, "gpo_after_rst");

      // Output register actions
      apb_wr(OFF_GPO,     32'h000F0, 4'hF);
      apb_wr(OFF_GPO_SET, 32'h00003, 4'hF);
      apb_wr(OFF_GPO_CLR, 32'h00010, 4'hF);
      apb_wr(OFF_GPO_TGL, 32'h00101, 4'hF);
      apb_rd(OFF_GPO, 32'h001E2, 1'b0, "gpo_set_clr_tgl");
      chk("gpo_pin", 32'(gpo), 32'h001E2);

      // Byte strobes and read-hold across a write
      apb_wr(OFF_GPD, 32'hFFFF_FFFF, 4'b0010);
      chk("rdata_hold", apb_rdata, 32'h001E2);
      apb_rd(OFF_GPD, 32'h0FF00, 1'b0, "gpd_strobe");
      chk("gpd_pin", 32'(gpd), 32'h0FF00);
      apb_rd(8'h40, 32'h0, 1'b0, "unmapped_0x40");
      apb_rd(OFF_GPO_SET, 32'h0, 1'b0, "set_reads_zero");

      // Bits above NUM_IO
      apb_wr(OFF_GPO, 32'hFFFF_FFFF, 4'hF);
      apb_rd(OFF_GPO, 32'h000F_FFFF, 1'b0, "gpo_width20");
      apb_rd(OFF_GPO, 32'h0000_00FF, 1'b1, "gpo_width8");

      // Synchronised input readback
      gpi = 20'hA5A5A;
      repeat (4) @(negedge clock);
      apb_rd(OFF_GPI, 32'h000A_5A5A, 1'b0, "gpi_read");
      gpi = '0;
      repeat (4) @(negedge clock);

      // All bits rising-edge, status cleared, only bit 3 enabled
      apb_wr(OFF_IRQ_TYPE, 32'h000F_FFFF, 4'hF);
      apb_wr(OFF_IRQ_POL,  32'h000F_FFFF, 4'hF);
      apb_wr(OFF_IRQ_STAT, 32'h000F_FFFF, 4'hF);
      apb_wr(OFF_IRQ_EN,   32'h0000_0008, 4'hF);
      apb_rd(OFF_IRQ_STAT, 32'h0, 1'b0, "stat_clean");
      gpi[3] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("intr_latency_c%0d", k), 32'(gpio_intr), (k >= 4) ? 32'h1 : 32'h0);
      end
      @(negedge clock);
      apb_rd(OFF_IRQ_STAT, 32'h8, 1'b0, "stat_rise3");
      apb_rd(OFF_IRQ_PEND, 32'h8, 1'b0, "pend_rise3");
      apb_wr(OFF_IRQ_STAT, 32'h8, 4'hF);
      repeat (2) @(negedge clock);
      chk("intr_after_w1c", 32'(gpio_intr), 32'h0);
      apb_rd(OFF_IRQ_STAT, 32'h0, 1'b0, "stat_after_w1c");

      // Both-edge mode; W1C coinciding with the second edge loses
      apb_wr(OFF_IRQ_BOTH, 32'h20, 4'hF);
      gpi[5] = 1'b1;
      repeat (10) @(negedge clock);
      apb_rd(OFF_IRQ_STAT, 32'h20, 1'b0, "both_first_edge");
      apb_wr(OFF_IRQ_STAT, 32'h20, 4'hF);
      apb_rd(OFF_IRQ_STAT, 32'h0, 1'b0, "both_cleared");
      repeat (6) @(negedge clock);
      gpi[5] = 1'b0;
      @(negedge clock);
      apb_wr(OFF_IRQ_STAT, 32'h20, 4'hF);
      apb_rd(OFF_IRQ_STAT, 32'h20, 1'b0, "set_beats_w1c");

      // Level-high on bit 0
      apb_wr(OFF_IRQ_STAT, 32'h000F_FFFF, 4'hF);
      apb_wr(OFF_IRQ_TYPE, 32'h000F_FFFE, 4'hF);
      apb_wr(OFF_IRQ_EN,   32'h1, 4'hF);
      apb_rd(OFF_IRQ_STAT, 32'h0, 1'b0, "level_idle");
      gpi[0] = 1'b1;
      repeat (5) @(negedge clock);
      chk("level_intr_on", 32'(gpio_intr), 32'h1);
      apb_wr(OFF_IRQ_STAT, 32'h1, 4'hF);
      apb_rd(OFF_IRQ_STAT, 32'h1, 1'b0, "level_w1c_blocked");
      gpi[0] = 1'b0;
      repeat (4) @(negedge clock);
      apb_wr(OFF_IRQ_STAT, 32'h1, 4'hF);
      apb_rd(OFF_IRQ_STAT, 32'h0, 1'b0, "level_w1c_ok");
      chk("level_intr_off", 32'(gpio_intr), 32'h0);

      // Asynchronous reset during an access phase
      gpi[0] = 1'b1;
      repeat (5) @(negedge clock);
      chk("pre_rst_intr", 32'(gpio_intr), 32'h1);
      apb_rd(OFF_GPO, 32'h000F_FFFF, 1'b0, "pre_rst_gpo");
      apb_addr = {24'h0, OFF_GPO}; apb_wdata = 32'h0; apb_pstb = 4'hF;
      apb_sel = 1'b1; apb_write = 1'b1; apb_ena = 1'b0;
      @(negedge clock);
      apb_ena = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_gpo",   32'(gpo), 32'h0);
      chk("async_gpd",   32'(gpd), 32'h0);
      chk("async_intr",  32'(gpio_intr), 32'h0);
      chk("async_rdata", apb_rdata, 32'h0);
      chk("async_gpo8",  32'(gpo8), 32'h0);
      @(negedge clock);
      apb_sel = 1'b0; apb_write = 1'b0; apb_ena = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      apb_rd(OFF_GPO, 32'h0, 1'b0, "post_rst_gpo");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
